arm7_mul_unit: RTL

Multi-cycle ARM7 multiply/multiply-accumulate unit covering MUL, MLA, UMULL, UMLAL, SMULL and SMLAL. It sits beside the ALU/shifter datapath in the execute stage and is started by the control FSM when a multiply is decoded. It retires `BITS_PER_CYCLE` bits of Rs per clock through a start/busy/done handshake. It generalises the single-cycle ALU/shifter datapath in three ways: parametrised operand width, parametrised radix, and 64-bit signed/unsigned long results with optional early termination.

---
 rtl/arm7_mul_unit_if.sv | 30 +++
 rtl/arm7_mul_unit.sv | 121 ++++++++++++
 2 files changed

// File: rtl/arm7_mul_unit_if.sv
// Start/busy/done handshake and operand/result bus of the ARM7 multiply unit.
`timescale 1ns/1ps
interface arm7_mul_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             is_long;
  logic             is_signed;
  logic             accumulate;
  logic [WIDTH-1:0] op_rm;
  logic [WIDTH-1:0] op_rs;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] acc_hi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             flag_n;
  logic             flag_z;

  modport master (
    output start, is_long, is_signed, accumulate, op_rm, op_rs, acc_lo, acc_hi,
    input  busy, done, result_lo, result_hi, flag_n, flag_z
  );

  modport slave (
    input  start, is_long, is_signed, accumulate, op_rm, op_rs, acc_lo, acc_hi,
    output busy, done, result_lo, result_hi, flag_n, flag_z
  );
endinterface

// File: rtl/arm7_mul_unit.sv
// Multi-cycle ARM7 MUL/MLA/UMULL/UMLAL/SMULL/SMLAL unit, BITS_PER_CYCLE Rs bits per clock.
// Define ARM7_MUL_EARLY_TERM_EN to stop iterating once the remaining Rs chunks are insignificant.
`timescale 1ns/1ps
module arm7_mul_unit #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 8
) (
  input  logic           clk,
  input  logic           reset,
  arm7_mul_unit_if.slave bus
);

  localparam int unsigned K      = BITS_PER_CYCLE;
  localparam int unsigned W2     = 2 * WIDTH;
  localparam int unsigned NCHUNK = WIDTH / K;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic              mode_long;
  logic              mode_sl;
  logic [W2-1:0]     rm_sh;
  logic [WIDTH-1:0]  rs_sh;
  logic [W2-1:0]     acc;
  logic [IW-1:0]     idx;

  logic [K-1:0]      chunk;
  logic              early;
  logic              last;
  logic              neg;
  logic [W2-1:0]     prod;
  logic [W2-1:0]     acc_nx;
  logic [WIDTH-1:0]  rs_nx;
  logic [WIDTH-1:0]  rs_upper;
  logic [W2-1:0]     rm_ext;
  logic [W2-1:0]     acc_init;

  // Rm and Rs are pre-shifted each iteration so chunk i always sits at Rs bit 0.
  always_comb begin
    chunk    = rs_sh[K-1:0];
    rs_upper = mode_sl ? WIDTH'($signed(rs_sh) >>> (K - 1)) : (rs_sh >> K);
`ifdef ARM7_MUL_EARLY_TERM_EN
    early    = mode_sl ? ((rs_upper == '0) || (rs_upper == '1)) : (rs_upper == '0);
`else
    early    = 1'b0;
`endif
    last     = (idx == IW'(NCHUNK - 1)) || early;
    // A signed final chunk weighs c - 2^k, so subtract Rm shifted by k.
    neg      = mode_sl && last && chunk[K-1];
    prod     = rm_sh * W2'(chunk);
    acc_nx   = acc + (neg ? (prod - (rm_sh << K)) : prod);
    rs_nx    = mode_sl ? WIDTH'($signed(rs_sh) >>> K) : (rs_sh >> K);
    rm_ext   = (bus.is_long && bus.is_signed) ? W2'($signed(bus.op_rm)) : W2'(bus.op_rm);
    acc_init = '0;
    if (bus.accumulate) begin
      acc_init = bus.is_long ? {bus.acc_hi, bus.acc_lo} : {WIDTH'(0), bus.acc_lo};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      mode_long     <= 1'b0;
      mode_sl       <= 1'b0;
      rm_sh         <= '0;
      rs_sh         <= '0;
      acc           <= '0;
      idx           <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.result_lo <= '0;
      bus.result_hi <= '0;
      bus.flag_n    <= 1'b0;
      bus.flag_z    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            mode_long <= bus.is_long;
            mode_sl   <= bus.is_long & bus.is_signed;
            rm_sh     <= rm_ext;
            rs_sh     <= bus.op_rs;
            acc       <= acc_init;
            idx       <= '0;
            bus.busy  <= 1'b1;
            state     <= S_ITER;
          end
        end
        S_ITER: begin
          acc   <= acc_nx;
          rm_sh <= rm_sh << K;
          rs_sh <= rs_nx;
          idx   <= idx + IW'(1);
          if (last) begin
            state         <= S_DONE;
            bus.done      <= 1'b1;
            bus.result_lo <= acc_nx[WIDTH-1:0];
            bus.result_hi <= mode_long ? acc_nx[W2-1:WIDTH] : '0;
            bus.flag_n    <= mode_long ? acc_nx[W2-1] : acc_nx[WIDTH-1];
            bus.flag_z    <= mode_long ? (acc_nx == '0) : (acc_nx[WIDTH-1:0] == '0);
          end
        end
        S_DONE: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
